// File: rtl/wave_gen.sv
// -----------------------------------------------------------------------------
// wave_gen -- programmable single-bit waveform generator
//
// Purpose
//   Runs a phase counter from 0 up to a terminal count and turns it into one of
//   four waveforms:
//     00 PATTERN : bit pat[phase] of a small writable pattern table
//     01 PWM     : high while phase < duty
//     10 SQUARE  : level that toggles each time the counter wraps
//     11 ONESHOT : pattern table, one pass per start trigger
//   The raw waveform is ANDed with the qualifier 'a' and with busy.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   run enable for PATTERN / PWM / SQUARE
//   start      in   level-sampled trigger for ONESHOT
//   a          in   output qualifier
//   mode       in   [1:0] waveform selection
//   period     in   [CNT_W-1:0] terminal count (cycle length period+1)
//   duty       in   [CNT_W-1:0] PWM high count
//   pat_wr     in   pattern table write strobe
//   pat_addr   in   [CNT_W-1:0] pattern table write address
//   pat_data   in   pattern table write data
//   out        out  qualified waveform
//   phase      out  [CNT_W-1:0] current counter value
//   busy       out  high while the FSM is in RUN
//   wrap       out  high in the running cycle where phase equals the
//                   latched terminal count
//
// Configuration
//   WAVE_GEN_OUT_REG_EN  defined : 'out' comes from a flop (one cycle later)
//                        absent  : 'out' is combinational from state and 'a'
// -----------------------------------------------------------------------------
module wave_gen #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic             a,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    input  logic             pat_wr,
    input  logic [CNT_W-1:0] pat_addr,
    input  logic             pat_data,
    output logic             out,
    output logic [CNT_W-1:0] phase,
    output logic             busy,
    output logic             wrap
);

    localparam int DEPTH = 1 << CNT_W;

    localparam logic [1:0] MODE_PATTERN = 2'b00;
    localparam logic [1:0] MODE_PWM     = 2'b01;
    localparam logic [1:0] MODE_SQUARE  = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    localparam logic [CNT_W-1:0] PHASE_ZERO = '0;
    localparam logic [CNT_W-1:0] PHASE_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q,  state_d;
    logic [CNT_W-1:0] phase_q,  phase_d;
    logic [1:0]       mode_q,   mode_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] duty_q,   duty_d;
    logic             sq_q,     sq_d;
    logic [DEPTH-1:0] pat_q;

    logic [DEPTH-1:0] pat_we;
    logic             at_term;
    logic             launch;
    logic             wave;
    logic             out_comb;

    // -------------------------------------------------------------------------
    // Status decode
    // -------------------------------------------------------------------------
    assign busy    = (state_q == ST_RUN);
    assign at_term = (phase_q == period_q);
    assign wrap    = busy & at_term;
    assign phase   = phase_q;

    // Launch condition depends on the live mode input: ONESHOT is started by
    // 'start', every other mode by 'en'.
    assign launch  = (mode == MODE_ONESHOT) ? start : en;

    // -------------------------------------------------------------------------
    // Pattern table: one flop per entry so reset can clear it. Write decode is
    // one enable per entry. A read in the write cycle sees the old contents
    // because the read path is taken straight from the flops.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pat_we
        assign pat_we[gi] = pat_wr && (pat_addr == CNT_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pat_we[i]) begin
                    pat_q[i] <= pat_data;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM + counter: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            mode_q   <= '0;
            period_q <= '0;
            duty_q   <= '0;
            sq_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            sq_q     <= sq_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM + counter: next state
    // Configuration is only sampled at launch and at each wrap, so mid-run
    // changes to mode/period/duty finish the current cycle untouched.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        mode_d   = mode_q;
        period_d = period_q;
        duty_d   = duty_q;

        // SQUARE level toggles on every wrap, including period==0 where
        // every running cycle is a wrap.
        sq_d     = sq_q ^ wrap;

        unique case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d  = ST_RUN;
                    phase_d  = PHASE_ZERO;
                    mode_d   = mode;
                    period_d = period;
                    duty_d   = duty;
                end
            end

            ST_RUN: begin
                if ((mode_q != MODE_ONESHOT) && !en) begin
                    // Continuous modes stop as soon as enable drops.
                    state_d = ST_IDLE;
                    phase_d = PHASE_ZERO;
                end else if (at_term) begin
                    // End of cycle: restart the counter and pick up any new
                    // configuration. A one-shot run ends here instead.
                    if (mode_q == MODE_ONESHOT) begin
                        state_d = ST_DONE;
                    end
                    phase_d  = PHASE_ZERO;
                    mode_d   = mode;
                    period_d = period;
                    duty_d   = duty;
                end else begin
                    // phase_q < period_q here, so this increment cannot wrap
                    // the CNT_W-bit counter.
                    phase_d = phase_q + PHASE_ONE;
                end
            end

            ST_DONE: begin
                // Wait for start to be released so a held trigger does not
                // fire a second pass.
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                phase_d = PHASE_ZERO;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Waveform selection (from latched mode, so it only changes at a wrap)
    // -------------------------------------------------------------------------
    always_comb begin
        wave = 1'b0;
        unique case (mode_q)
            MODE_PATTERN: wave = pat_q[phase_q];
            MODE_PWM:     wave = (phase_q < duty_q);
            MODE_SQUARE:  wave = sq_q;
            MODE_ONESHOT: wave = pat_q[phase_q];
            default:      wave = 1'b0;
        endcase
    end

    // busy gates the output so IDLE and DONE always drive 0.
    assign out_comb = wave & a & busy;

`ifdef WAVE_GEN_OUT_REG_EN
    logic out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_comb;
        end
    end

    assign out = out_q;
`else
    assign out = out_comb;
`endif

endmodule

// File: tb/tb_wave_gen.sv
// -----------------------------------------------------------------------------
// tb_wave_gen -- self-checking bench for wave_gen (CNT_W = 3)
// A cycle-level reference model tracks run state, counter and latched
// configuration; every sampled cycle is compared against it, and directed
// scenarios are additionally compared against fixed expected sequences.
// -----------------------------------------------------------------------------
module tb_wave_gen;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          start;
    logic          a;
    logic [1:0]    mode;
    logic [CW-1:0] period;
    logic [CW-1:0] duty;
    logic          pat_wr;
    logic [CW-1:0] pat_addr;
    logic          pat_data;
    logic          out;
    logic [CW-1:0] phase;
    logic          busy;
    logic          wrap;

    wave_gen #(.CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .start    (start),
        .a        (a),
        .mode     (mode),
        .period   (period),
        .duty     (duty),
        .pat_wr   (pat_wr),
        .pat_addr (pat_addr),
        .pat_data (pat_data),
        .out      (out),
        .phase    (phase),
        .busy     (busy),
        .wrap     (wrap)
    );

    initial forever #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model (0 idle, 1 running, 2 done)
    // -------------------------------------------------------------------------
    int m_state;
    int m_phase;
    int m_mode;
    int m_period;
    int m_duty;
    int m_sq;
    int m_pat[8];
    int m_out_reg;

    task automatic m_reset();
        m_state   = 0;
        m_phase   = 0;
        m_mode    = 0;
        m_period  = 0;
        m_duty    = 0;
        m_sq      = 0;
        m_out_reg = 0;
        for (int i = 0; i < 8; i++) m_pat[i] = 0;
    endtask

    function automatic int m_wave();
        if (m_mode == 1) return (m_phase < m_duty) ? 1 : 0;
        if (m_mode == 2) return m_sq;
        return m_pat[m_phase];
    endfunction

    function automatic int m_out_now();
        return (m_state == 1 && a) ? m_wave() : 0;
    endfunction

    function automatic int m_exp_out();
`ifdef WAVE_GEN_OUT_REG_EN
        return m_out_reg;
`else
        return m_out_now();
`endif
    endfunction

    function automatic int m_exp_wrap();
        return (m_state == 1 && m_phase == m_period) ? 1 : 0;
    endfunction

    // Advance the model by one rising edge using the current inputs.
    task automatic m_step();
        int was_wrap;
        int nxt_out;
        if (!rst_n) begin
            m_reset();
        end else begin
            nxt_out  = m_out_now();
            was_wrap = m_exp_wrap();
            if (was_wrap != 0) m_sq = 1 - m_sq;
            if (m_state == 0) begin
                if ((mode != 3 && en) || (mode == 3 && start)) begin
                    m_state  = 1;
                    m_phase  = 0;
                    m_mode   = mode;
                    m_period = period;
                    m_duty   = duty;
                end
            end else if (m_state == 1) begin
                if (m_mode != 3 && !en) begin
                    m_state = 0;
                    m_phase = 0;
                end else if (was_wrap != 0) begin
                    if (m_mode == 3) m_state = 2;
                    m_phase  = 0;
                    m_mode   = mode;
                    m_period = period;
                    m_duty   = duty;
                end else begin
                    m_phase = m_phase + 1;
                end
            end else begin
                if (!start) m_state = 0;
            end
            if (pat_wr) m_pat[pat_addr] = pat_data;
            m_out_reg = nxt_out;
        end
    endtask

    // -------------------------------------------------------------------------
    // One clock: compare at the falling edge, step the model at the rising
    // edge, return 1 time unit later so the caller can drive new inputs.
    // -------------------------------------------------------------------------
    logic          obs_out;
    logic          obs_busy;
    logic          obs_wrap;
    logic [CW-1:0] obs_phase;

    task automatic tick();
        @(negedge clk);
        check_eq("out",   out,   m_exp_out());
        check_eq("phase", phase, m_phase);
        check_eq("busy",  busy,  (m_state == 1) ? 1 : 0);
        check_eq("wrap",  wrap,  m_exp_wrap());
        obs_out   = out;
        obs_busy  = busy;
        obs_wrap  = wrap;
        obs_phase = phase;
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic go_idle();
        en    = 1'b0;
        start = 1'b0;
        repeat (10) tick();
    endtask

    // Run a continuous mode from IDLE and compare out/wrap against a fixed
    // per-cycle table (bit i = cycle i of the waveform period).
    task automatic run_fixed(input string tag, input logic [1:0] md,
                             input logic [CW-1:0] per, input logic [CW-1:0] dt,
                             input logic [7:0] bits, input int len, input int n);
        int idx;
        int e;
        go_idle();
        mode   = md;
        period = per;
        duty   = dt;
        a      = 1'b1;
        en     = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            tick();
            idx = i % len;
`ifdef WAVE_GEN_OUT_REG_EN
            e = (i == 0) ? 0 : int'(bits[(i - 1) % len]);
`else
            e = int'(bits[idx]);
`endif
            check_eq({tag, "_out"},  obs_out,  e);
            check_eq({tag, "_wrap"}, obs_wrap, (idx == len - 1) ? 1 : 0);
            check_eq({tag, "_busy"}, obs_busy, 1);
        end
        $display("%s: %0d cycles checked", tag, n);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    logic [7:0] pat_v;
    int         bcnt;
    int         wcnt;
    int         exp_ph[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 0, 1, 2, 0, 1};

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        start    = 1'b0;
        a        = 1'b0;
        mode     = 2'b00;
        period   = '0;
        duty     = '0;
        pat_wr   = 1'b0;
        pat_addr = '0;
        pat_data = 1'b0;
        m_reset();

        #1;
        check_eq("rst_out",   out,   0);
        check_eq("rst_phase", phase, 0);
        check_eq("rst_busy",  busy,  0);
        check_eq("rst_wrap",  wrap,  0);
        tick();
        tick();
        rst_n = 1'b1;
        $display("reset released");

        // Load pattern 1011_0010 (address 0 = LSB) while idle.
        pat_v = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            pat_wr   = 1'b1;
            pat_addr = CW'(i);
            pat_data = pat_v[i];
            tick();
        end
        pat_wr = 1'b0;
        $display("pattern loaded");

        run_fixed("pattern", 2'b00, 3'd7, 3'd0, 8'b1011_0010, 8, 16);
        run_fixed("pwm_d2",  2'b01, 3'd4, 3'd2, 8'b0000_0011, 5, 10);
        run_fixed("pwm_d5",  2'b01, 3'd4, 3'd5, 8'b0001_1111, 5, 10);
        run_fixed("pwm_d0",  2'b01, 3'd4, 3'd0, 8'b0000_0000, 5, 10);

        // ONESHOT: start held for 10 cycles gives exactly one 4-cycle pass.
        go_idle();
        mode   = 2'b11;
        period = 3'd3;
        a      = 1'b1;
        start  = 1'b1;
        tick();
        bcnt = 0;
        wcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            bcnt += int'(obs_busy);
            wcnt += int'(obs_wrap);
        end
        check_eq("os_busy_cycles", bcnt, 4);
        check_eq("os_wraps",       wcnt, 1);
        start = 1'b0;
        tick();
        tick();
        bcnt = 0;
        repeat (4) begin
            tick();
            bcnt += int'(obs_busy);
        end
        check_eq("os_no_rerun", bcnt, 0);
        $display("oneshot: busy %0d wraps %0d", 4, 1);

        // Mid-run period change 7 -> 2 takes effect after the current cycle.
        go_idle();
        mode   = 2'b01;
        period = 3'd7;
        duty   = 3'd3;
        a      = 1'b1;
        en     = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            check_eq("mid_phase", obs_phase, exp_ph[i]);
            if (i == 3) period = 3'd2;
        end
        $display("mid-run period change checked");

        // Asynchronous reset between edges at phase 5.
        go_idle();
        mode   = 2'b00;
        period = 3'd7;
        a      = 1'b1;
        en     = 1'b1;
        tick();
        repeat (5) tick();
        check_eq("pre_rst_phase", phase, 5);
        check_eq("pre_rst_out",   out,   1);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_eq("arst_out",   out,   0);
        check_eq("arst_phase", phase, 0);
        check_eq("arst_busy",  busy,  0);
        check_eq("arst_wrap",  wrap,  0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("cleared_pat_out", obs_out,  0);
            check_eq("restart_busy",    obs_busy, 1);
        end
        $display("async reset checked");

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n = 1'b1;
            if ($urandom_range(15) == 0) en = ~en;
            if ($urandom_range(7) == 0)  start = ~start;
            a = ($urandom_range(7) != 0);
            if ($urandom_range(9) == 0) mode   = 2'($urandom_range(3));
            if ($urandom_range(5) == 0) period = CW'($urandom_range(7));
            if ($urandom_range(5) == 0) duty   = CW'($urandom_range(7));
            pat_wr   = ($urandom_range(3) == 0);
            pat_addr = CW'($urandom_range(7));
            pat_data = 1'($urandom_range(1));
            if ($urandom_range(599) == 0) begin
                rst_n = 1'b0;
                m_reset();
            end
            tick();
        end
        rst_n = 1'b1;
        $display("random: 3000 cycles checked");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wave_gen.md
WAVE_GEN -- requirements
Module: wave_gen

Interface
REQ-001 Parameter CNT_W, default 3: phase counter width; pattern table depth is 2**CNT_W entries of 1 bit.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  continuous-run enable (modes PATTERN, PWM, SQUARE).
REQ-005 start  input  1  one-shot trigger (mode ONESHOT), level-sampled.
REQ-006 a  input  1  output qualifier; final waveform ANDed with a.
REQ-007 mode  input  2  00 PATTERN, 01 PWM, 10 SQUARE, 11 ONESHOT.
REQ-008 period  input  CNT_W  terminal count; cycle length = period+1.
REQ-009 duty  input  CNT_W  PWM high count.
REQ-010 pat_wr  input  1  pattern table write strobe.
REQ-011 pat_addr  input  CNT_W  pattern table write address.
REQ-012 pat_data  input  1  pattern table write data.
REQ-013 out  output  1  generated waveform.
REQ-014 phase  output  CNT_W  current counter value.
REQ-015 busy  output  1  high while FSM in RUN.
REQ-016 wrap  output  1  one-cycle pulse in the cycle phase==period_q while running.

Function
REQ-017 FSM states IDLE, RUN, DONE; IDLE->RUN when (mode!=11 and en=1) or (mode=11 and start=1).
REQ-018 On IDLE->RUN: phase<=0; mode, period, duty latched into mode_q, period_q, duty_q.
REQ-019 In RUN: phase==period_q -> phase<=0, re-latch mode/period/duty; else phase<=phase+1.
REQ-020 RUN->IDLE when mode_q!=11 and en=0; phase<=0 same edge.
REQ-021 RUN->DONE on wrap when mode_q=11; DONE->IDLE when start=0 (no retrigger while start held).
REQ-022 Raw waveform w: PATTERN/ONESHOT w=pat[phase]; PWM w=(phase<duty_q); SQUARE w=sq, sq toggles on each wrap.
REQ-023 out = w & a & busy; out=0 in IDLE and DONE.
REQ-024 period=0: wrap asserted every RUN cycle, phase stays 0, SQUARE toggles every cycle.
REQ-025 duty=0 -> PWM out constant 0; duty>period -> PWM out constant 1 (qualified by a).
REQ-026 Input changes to mode/period/duty mid-run take effect only at next wrap.
REQ-027 pat_wr writes pat[pat_addr] at edge, allowed in any state; read of same address in same cycle returns old value.
REQ-028 Counter never exceeds period_q; no CNT_W overflow possible.

Reset
REQ-029 rst_n=0 asynchronously forces: state IDLE, phase 0, sq 0, busy 0, wrap 0, out 0, latched config 0.
REQ-030 Pattern table cleared to all 0 by reset.
REQ-031 Reset asserted mid-run aborts immediately; after release FSM waits for fresh en/start.

Configuration
REQ-032 Macro WAVE_GEN_OUT_REG_EN defined: out registered (reset 0), one cycle after w/a/busy; wrap unchanged.
REQ-033 Macro absent: out combinational from registered state and a, zero added latency.

Verification (CNT_W=3, macro absent unless noted)
REQ-034 PATTERN: pat=8'b1011_0010 (addr0=LSB), period=7, a=1, en=1 -> out per cycle 0,1,0,0,1,1,0,1 repeating, wrap every 8th cycle.
REQ-035 PWM: period=4, duty=2, a=1 -> out 1,1,0,0,0 repeating; duty=5 -> constant 1; duty=0 -> constant 0.
REQ-036 ONESHOT: period=3, start pulsed held 10 cycles -> busy 4 cycles, wrap once, DONE until start low, no second run.
REQ-037 Mid-run change: PWM period 7->2 written at phase 3 -> current cycle ends at phase 7, next cycles length 3.
REQ-038 Async reset at phase 5 between clock edges -> out, phase, busy 0 immediately; pattern reads all 0 after restart.
REQ-039 With WAVE_GEN_OUT_REG_EN: REQ-034 stimulus -> identical out sequence delayed one clk; a=0 pulse masks out one cycle later.
